io_mem_scheduler: RTL and testbench
===================================

# io_mem_scheduler

Round-robin scheduler that shares one single-ported IO memory between `IO_COUNT` requesters, such as the VGA frame reader and the CPU IO window. It accepts at most one request per cycle and drives the memory port from registers. It tracks in-flight reads in a tag pipeline matched to the fixed memory read latency, and returns each read word to the requester that issued it. It sits between the IO devices and the IO memory, next to the CPU's IO bus.

## Interface
Parameters:
- `WORD_SIZE`, default `gc::WORD_SIZE`: data and address width.
- `IO_COUNT`, default 4: number of requesters. Legal range is 2..8.
- `MEM_LATENCY`, default 2: cycles from `memRd` high to `memDataIn` valid. Must be ≥1.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active high.
- `req`  in  IO_COUNT: per-requester request, level. Held until granted.
- `reqWe`  in  IO_COUNT: per-requester write flag. 1 = write, 0 = read.
- `reqAddr`  in  IO_COUNT*WORD_SIZE: flat address bus. Requester i uses slice [i*WORD_SIZE +: WORD_SIZE].
- `reqData`  in  IO_COUNT*WORD_SIZE: flat write-data bus, sliced the same way as `reqAddr`.
- `gnt`  out  IO_COUNT: one-hot grant, combinational.
- `rdata`  out  WORD_SIZE: read data shared by all requesters.
- `rvalid`  out  IO_COUNT: one-hot strobe marking `rdata` valid for that requester.
- `memAdd`  out  WORD_SIZE: memory address.
- `memRd`  out  1: memory read strobe.
- `memWe`  out  1: memory write strobe.
- `memDataOut`  out  WORD_SIZE: memory write data.
- `memDataIn`  in  WORD_SIZE: memory read data.

## Operation
Arbitration:
- Pointer `ptr` has width ceil(log2 IO_COUNT). Reset value is 0.
- The winner is the first i with `req[i]=1`, searching from `ptr` upward modulo IO_COUNT.
- `gnt` is one-hot for the winner, or all zero when no `req` is high. It is a pure function of `req` and `ptr`.
- A transfer is accepted on any edge where `gnt[i]=1`. On that edge `ptr` ← (i+1) mod IO_COUNT.
- `ptr` is unchanged when `gnt` is all zero.
- Requesters must not make `req` depend combinationally on `gnt`.
- Holding `req` high after an accept means a new back-to-back request.
- A requester may drop `req` before it is granted; no transfer occurs.

Issue stage (registered):
- On an accept by i, load `memAdd`, `memDataOut` and `memWe` from requester i's slices and `reqWe[i]`.
- `memRd` ← ~`reqWe[i]`.
- With no accept, `memRd` and `memWe` ← 0. `memAdd` and `memDataOut` hold their values.

Return path:
- Tag shift register, MEM_LATENCY stages. Each stage holds {valid, requester index}.
- The issue of a read pushes {1, i}. Writes and idle cycles push {0, x}.
- When the tail stage is valid with index k: `rdata` ← `memDataIn` and `rvalid` ← one-hot(k) at the next edge. Otherwise `rvalid` ← 0 and `rdata` holds.
- Writes produce no response and no acknowledgement beyond `gnt`.

Reset:
- `ptr`, `memRd`, `memWe`, `rvalid` and all tag-valid bits ← 0. `memAdd`, `memDataOut` and `rdata` ← 0.
- Reset mid-operation drops in-flight reads: no `rvalid` is ever produced for them.
- While `rst` is high, `gnt` is forced to 0.

## Timing
Cycle numbers below use C0 as the cycle in which `gnt[i]` is high.
- Accept happens at the end of C0.
- `memRd` or `memWe` is high in C1.
- `memDataIn` is sampled at the end of C(1+MEM_LATENCY).
- `rvalid[i]` is high in C(2+MEM_LATENCY).
- Read latency from grant to `rvalid` is therefore MEM_LATENCY+2 cycles.
- Throughput is one transfer per cycle, with reads and writes in any mix. Reads return strictly in issue order.
- `rvalid` is a one-cycle pulse and at most one bit is set.

## Test plan
- Single read: MEM_LATENCY=2. `req[1]` with address 0x0010, memory model returns 0xBEEF. Expect `gnt[1]` in C0, `memRd`=1 and `memAdd`=0x0010 in C1, `rvalid`=0b0010 with `rdata`=0xBEEF in C4. `ptr` ends at 2.
- Full contention: all 4 `req` held high for 8 cycles after reset. Expect grant order 0,1,2,3,0,1,2,3, and 8 `rvalid` pulses in the same order, 4 cycles after each grant.
- Back-to-back single requester: `req[2]` held high for 3 cycles, addresses 5, 6, 7. Expect 3 consecutive grants, `memAdd` 5, 6, 7 in consecutive cycles, and three consecutive `rvalid[2]` pulses.
- Write: `req[3]` with `reqWe[3]`=1, address 0x20, data 0x1234. Expect `memWe`=1, `memRd`=0, `memAdd`=0x20, `memDataOut`=0x1234 in C1, and no `rvalid` at any time.
- Reset mid-flight: grant reads for requesters 0 and 1 in consecutive cycles, assert `rst` one cycle after the second grant. Expect no `rvalid` pulses, all outputs 0, and a fresh request after reset granted with `ptr`=0 priority.
- Withdrawn request: `req[1]` and `req[2]` with `ptr`=1, then `req[2]` dropped while `req[1]` is being granted. Expect no transfer for 2 and `ptr`=2 afterward.

Source files
------------

// File: rtl/io_mem_scheduler.sv
// io_mem_scheduler: round-robin sharing of one single-ported IO memory between IO requesters
package gc;
   localparam int WORD_SIZE = 16;
endpackage

module io_mem_scheduler #(
   parameter int WORD_SIZE = gc::WORD_SIZE,
   parameter int IO_COUNT = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IO_COUNT-1:0]           req,
   input  logic [IO_COUNT-1:0]           reqWe,
   input  logic [IO_COUNT*WORD_SIZE-1:0] reqAddr,
   input  logic [IO_COUNT*WORD_SIZE-1:0] reqData,
   output logic [IO_COUNT-1:0]           gnt,
   output logic [WORD_SIZE-1:0]          rdata,
   output logic [IO_COUNT-1:0]           rvalid,
   output logic [WORD_SIZE-1:0]          memAdd,
   output logic                          memRd,
   output logic                          memWe,
   output logic [WORD_SIZE-1:0]          memDataOut,
   input  logic [WORD_SIZE-1:0]          memDataIn
);
   localparam int PW = $clog2(IO_COUNT);
   logic [PW-1:0] ptr, winIdx, nextPtr, issueIdx;
   logic found, accept;
   int cand;
   logic [MEM_LATENCY-1:0] tagValid;
   logic [PW-1:0] tagIdx [MEM_LATENCY];

   // rotating-priority search from ptr; the last hit in the descending scan is the nearest one
   always_comb begin
      found = 1'b0;
      winIdx = '0;
      cand = 0;
      for (int k = IO_COUNT - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % IO_COUNT;
         if (req[PW'(cand)]) begin
            found = 1'b1;
            winIdx = PW'(cand);
         end
      end
      gnt = (found && !rst) ? IO_COUNT'(1) << winIdx : '0;
      accept = |gnt;
      nextPtr = (winIdx == PW'(IO_COUNT - 1)) ? '0 : winIdx + PW'(1);
   end

   // issue stage: the winner's request is registered onto the memory port
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         memRd <= 1'b0;
         memWe <= 1'b0;
         memAdd <= '0;
         memDataOut <= '0;
         issueIdx <= '0;
      end else if (accept) begin
         ptr <= nextPtr;
         memRd <= ~reqWe[winIdx];
         memWe <= reqWe[winIdx];
         memAdd <= reqAddr[winIdx*WORD_SIZE +: WORD_SIZE];
         memDataOut <= reqData[winIdx*WORD_SIZE +: WORD_SIZE];
         issueIdx <= winIdx;
      end else begin
         memRd <= 1'b0;
         memWe <= 1'b0;
      end
   end

   // tag pipeline follows each read through the memory latency; reset drops in-flight reads
   always_ff @(posedge clk) begin
      if (rst) begin
         tagValid <= '0;
      end else begin
         tagValid[0] <= memRd;
         for (int s = 1; s < MEM_LATENCY; s++) tagValid[s] <= tagValid[s-1];
      end
      tagIdx[0] <= issueIdx;
      for (int s = 1; s < MEM_LATENCY; s++) tagIdx[s] <= tagIdx[s-1];
   end

   // return path: capture read data and strobe the requester that issued it
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
         rvalid <= '0;
      end else begin
         rvalid <= tagValid[MEM_LATENCY-1] ? IO_COUNT'(1) << tagIdx[MEM_LATENCY-1] : '0;
         if (tagValid[MEM_LATENCY-1]) rdata <= memDataIn;
      end
   end
endmodule

// File: tb/tb_io_mem_scheduler.sv
// tb_io_mem_scheduler: scoreboard bench for the round-robin IO memory scheduler
module tb_io_mem_scheduler;
   localparam int W = 16;
   localparam int N = 4;
   localparam int L = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] reqWe = '0;
   logic [N*W-1:0] reqAddr = '0;
   logic [N*W-1:0] reqData = '0;
   logic [N-1:0] gnt, rvalid;
   logic [W-1:0] rdata, memAdd, memDataOut, memDataIn;
   logic memRd, memWe;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int mptr = 0;
   logic [W-1:0] mem [256];
   logic [W-1:0] pipe [L];

   typedef struct {int idx; logic [W-1:0] data; int due;} exp_t;
   exp_t sb[$];
   logic eRd = 1'b0, eWe = 1'b0;
   logic [W-1:0] eAdd = '0, eDout = '0;

   always #5 clk = ~clk;

   io_mem_scheduler #(.WORD_SIZE(W), .IO_COUNT(N), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req(req), .reqWe(reqWe), .reqAddr(reqAddr), .reqData(reqData),
      .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .memAdd(memAdd), .memRd(memRd), .memWe(memWe),
      .memDataOut(memDataOut), .memDataIn(memDataIn)
   );

   // memory model: writes land at the edge, reads appear L cycles after the read strobe
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (memWe === 1'b1) mem[memAdd[7:0]] = memDataOut;
      pipe[0] <= memAdd;
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
   end
   assign memDataIn = mem[pipe[L-1][7:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: predicts grants, the issue stage and the read returns every cycle
   task automatic monitor();
      logic [N-1:0] expV, expG;
      int w, c;
      forever begin
         @(negedge clk);
         expV = (sb.size() > 0 && sb[0].due == cyc) ? N'(1) << sb[0].idx : '0;
         tests++;
         if (rvalid !== expV) begin
            fails++;
            $display("FAIL rvalid cyc=%0d got=%b want=%b", cyc, rvalid, expV);
         end else if (expV != 0) begin
            tests++;
            if (rdata !== sb[0].data) begin
               fails++;
               $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, rdata, sb[0].data);
            end
         end
         while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
         tests++;
         if ({memRd, memWe, memAdd, memDataOut} !== {eRd, eWe, eAdd, eDout}) begin
            fails++;
            $display("FAIL issue cyc=%0d got rd=%b we=%b a=%h d=%h want rd=%b we=%b a=%h d=%h",
                     cyc, memRd, memWe, memAdd, memDataOut, eRd, eWe, eAdd, eDout);
         end
         w = -1;
         if (!rst) for (int k = N - 1; k >= 0; k--) begin
            c = (mptr + k) % N;
            if (req[c]) w = c;
         end
         expG = (w >= 0) ? N'(1) << w : '0;
         tests++;
         if (gnt !== expG) begin
            fails++;
            $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, expG);
         end
         if (rst) begin
            sb.delete();
            mptr = 0;
            eRd = 1'b0;
            eWe = 1'b0;
            eAdd = '0;
            eDout = '0;
         end else if (w >= 0) begin
            eAdd = reqAddr[w*W +: W];
            eDout = reqData[w*W +: W];
            eWe = reqWe[w];
            eRd = !reqWe[w];
            if (!reqWe[w]) sb.push_back('{w, mem[eAdd[7:0]], cyc + L + 2});
            mptr = (w + 1) % N;
         end else begin
            eRd = 1'b0;
            eWe = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '1;
      repeat (2) tick();
      @(negedge clk);
      tests++;
      if (gnt !== '0) begin
         fails++;
         $display("FAIL reset_gnt got=%b want=0000", gnt);
      end
      tests++;
      if ({rvalid, rdata, memRd, memWe, memAdd, memDataOut} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got rv=%b rd=%h mrd=%b mwe=%b a=%h d=%h want all 0",
                  rvalid, rdata, memRd, memWe, memAdd, memDataOut);
      end
      tick();
      rst = 1'b0;
      req = '0;
   endtask

   task automatic test_single_read();
      reqAddr[1*W +: W] = 16'h0010;
      reqWe = '0;
      req = 4'b0010;
      @(negedge clk);
      tests++;
      if (gnt !== 4'b0010) begin
         fails++;
         $display("FAIL single_gnt got=%b want=0010", gnt);
      end
      tick();
      req = '0;
      @(negedge clk);
      tests++;
      if (memRd !== 1'b1 || memAdd !== 16'h0010) begin
         fails++;
         $display("FAIL single_issue got rd=%b a=%h want rd=1 a=0010", memRd, memAdd);
      end
      repeat (3) tick();
      @(negedge clk);
      tests++;
      if (rvalid !== 4'b0010 || rdata !== 16'hBEEF) begin
         fails++;
         $display("FAIL single_return got rv=%b d=%h want rv=0010 d=beef", rvalid, rdata);
      end
      tick();
      reqAddr[2*W +: W] = 16'h0030;
      req = 4'b0110;
      @(negedge clk);
      tests++;
      if (gnt !== 4'b0100) begin
         fails++;
         $display("FAIL single_ptr got=%b want=0100", gnt);
      end
      tick();
      req = '0;
   endtask

   task automatic test_contention();
      int pulses;
      logic [N-1:0] want;
      pulses = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) reqAddr[i*W +: W] = W'(16'h0040 + i);
      reqWe = '0;
      req = '1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) req = '0;
         @(negedge clk);
         if (k < 8) begin
            want = N'(1) << (k % N);
            tests++;
            if (gnt !== want) begin
               fails++;
               $display("FAIL contention_gnt k=%0d got=%b want=%b", k, gnt, want);
            end
         end
         if (k >= 4 && k < 12) begin
            want = N'(1) << ((k - 4) % N);
            tests++;
            if (rvalid !== want) begin
               fails++;
               $display("FAIL contention_rvalid k=%0d got=%b want=%b", k, rvalid, want);
            end
         end
         if (rvalid != '0) pulses++;
         tick();
      end
      tests++;
      if (pulses != 8) begin
         fails++;
         $display("FAIL contention_pulses got=%0d want=8", pulses);
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 9; j++) begin
         if (j < 3) begin
            reqAddr[2*W +: W] = W'(5 + j);
            req = 4'b0100;
         end else req = '0;
         @(negedge clk);
         if (j < 3) begin
            tests++;
            if (gnt !== 4'b0100) begin
               fails++;
               $display("FAIL b2b_gnt j=%0d got=%b want=0100", j, gnt);
            end
         end
         if (j >= 1 && j < 4) begin
            tests++;
            if (memRd !== 1'b1 || memAdd !== W'(4 + j)) begin
               fails++;
               $display("FAIL b2b_issue j=%0d got rd=%b a=%h want rd=1 a=%h", j, memRd, memAdd, W'(4 + j));
            end
         end
         if (j >= 4 && j < 8) begin
            tests++;
            if (rvalid !== (j < 7 ? 4'b0100 : 4'b0000)) begin
               fails++;
               $display("FAIL b2b_rvalid j=%0d got=%b want=%b", j, rvalid, (j < 7 ? 4'b0100 : 4'b0000));
            end
         end
         tick();
      end
   endtask

   task automatic test_write();
      int pulses;
      pulses = 0;
      reqAddr[3*W +: W] = 16'h0020;
      reqData[3*W +: W] = 16'h1234;
      reqWe = 4'b1000;
      req = 4'b1000;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j == 0) begin
            tests++;
            if (gnt !== 4'b1000) begin
               fails++;
               $display("FAIL write_gnt got=%b want=1000", gnt);
            end
         end
         if (j == 1) begin
            tests++;
            if (memWe !== 1'b1 || memRd !== 1'b0 || memAdd !== 16'h0020 || memDataOut !== 16'h1234) begin
               fails++;
               $display("FAIL write_issue got we=%b rd=%b a=%h d=%h want we=1 rd=0 a=0020 d=1234",
                        memWe, memRd, memAdd, memDataOut);
            end
         end
         if (rvalid != '0) pulses++;
         tick();
         req = '0;
         reqWe = '0;
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL write_rvalid got=%0d pulses want=0", pulses);
      end
   endtask

   task automatic test_reset_midflight();
      int pulses;
      pulses = 0;
      reqAddr[0*W +: W] = 16'h0050;
      reqAddr[1*W +: W] = 16'h0051;
      req = 4'b0011;
      for (int j = 0; j < 10; j++) begin
         if (j == 2) begin
            req = '0;
            rst = 1'b1;
         end
         if (j == 3) rst = 1'b0;
         @(negedge clk);
         if (j < 2) begin
            tests++;
            if (gnt !== N'(1) << j) begin
               fails++;
               $display("FAIL midflight_gnt j=%0d got=%b want=%b", j, gnt, N'(1) << j);
            end
         end
         if (j == 3) begin
            tests++;
            if ({gnt, rvalid, rdata, memRd, memWe, memAdd, memDataOut} !== '0) begin
               fails++;
               $display("FAIL midflight_outputs got g=%b rv=%b rd=%h mrd=%b mwe=%b a=%h d=%h want all 0",
                        gnt, rvalid, rdata, memRd, memWe, memAdd, memDataOut);
            end
         end
         if (rvalid != '0) pulses++;
         tick();
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL midflight_rvalid got=%0d pulses want=0", pulses);
      end
      reqAddr[3*W +: W] = 16'h0060;
      req = 4'b1001;
      @(negedge clk);
      tests++;
      if (gnt !== 4'b0001) begin
         fails++;
         $display("FAIL midflight_fresh got=%b want=0001", gnt);
      end
      tick();
      req = '0;
   endtask

   task automatic test_withdrawn();
      reqAddr[1*W +: W] = 16'h0070;
      reqAddr[2*W +: W] = 16'h0071;
      req = 4'b0110;
      @(negedge clk);
      tests++;
      if (gnt !== 4'b0010) begin
         fails++;
         $display("FAIL withdrawn_gnt got=%b want=0010", gnt);
      end
      tick();
      req = '0;
      @(negedge clk);
      tests++;
      if (memRd !== 1'b1 || memAdd !== 16'h0070) begin
         fails++;
         $display("FAIL withdrawn_issue got rd=%b a=%h want rd=1 a=0070", memRd, memAdd);
      end
      tick();
      @(negedge clk);
      tests++;
      if (memRd !== 1'b0 || memWe !== 1'b0) begin
         fails++;
         $display("FAIL withdrawn_idle got rd=%b we=%b want rd=0 we=0", memRd, memWe);
      end
      tick();
      req = 4'b0110;
      @(negedge clk);
      tests++;
      if (gnt !== 4'b0100) begin
         fails++;
         $display("FAIL withdrawn_ptr got=%b want=0100", gnt);
      end
      tick();
      req = '0;
      repeat (10) tick();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = W'(16'h1000 + i * 7);
      mem[8'h10] = 16'hBEEF;
      fork
         monitor();
      join_none
      test_reset();
      test_single_read();
      test_contention();
      test_back_to_back();
      test_write();
      test_reset_midflight();
      test_withdrawn();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
